// File: rtl/fifo_bist_pkg.sv
// Shared definitions for the FIFO BIST write-side generator and read-side checker.
package fifo_bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } bist_state_t;

  localparam logic [1:0] PAT_INC   = 2'b00;
  localparam logic [1:0] PAT_CHK   = 2'b01;
  localparam logic [1:0] PAT_WALK  = 2'b10;
  localparam logic [1:0] PAT_ONOFF = 2'b11;

endpackage

// File: rtl/bist_pattern_gen.sv
// BIST pattern sequencer: LOAD restarts the sequence at word 0, ADV steps to the next word.
// PATTERN always shows the word at the current index for the pattern captured on LOAD.
module bist_pattern_gen
  import fifo_bist_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SEED       = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  adv,
  input  logic [1:0]            pat_sel,
  output logic [DATA_WIDTH-1:0] pattern
);

  localparam int POS_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [DATA_WIDTH-1:0] SEED_V   = DATA_WIDTH'(SEED);
  localparam logic [DATA_WIDTH-1:0] ONE_D    = DATA_WIDTH'(1);
  localparam logic [POS_W-1:0]      POS_SEED = POS_W'(SEED % DATA_WIDTH);
  localparam logic [POS_W-1:0]      POS_LAST = POS_W'(DATA_WIDTH - 1);
  localparam logic [POS_W-1:0]      ONE_P    = POS_W'(1);

  logic [1:0]            sel_r;
  logic [DATA_WIDTH-1:0] inc_r;
  logic [POS_W-1:0]      pos_r;
  logic                  odd_r;

  // Sequence state: pattern select, incrementing value, walking-one position, word parity
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_r <= 2'b00;
      inc_r <= '0;
      pos_r <= '0;
      odd_r <= 1'b0;
    end else if (load) begin
      sel_r <= pat_sel;
      inc_r <= SEED_V;
      pos_r <= POS_SEED;
      odd_r <= 1'b0;
    end else if (adv) begin
      inc_r <= inc_r + ONE_D;
      pos_r <= (pos_r == POS_LAST) ? '0 : pos_r + ONE_P;
      odd_r <= ~odd_r;
    end
  end

  // Word decode for the selected pattern
  always_comb begin
    pattern = '0;
    case (sel_r)
      PAT_INC:   pattern = inc_r;
      PAT_CHK:   pattern = odd_r ? {(DATA_WIDTH/2){2'b10}} : {(DATA_WIDTH/2){2'b01}};
      PAT_WALK:  pattern = ONE_D << pos_r;
      PAT_ONOFF: pattern = odd_r ? '1 : '0;
      default:   pattern = '0;
    endcase
  end

endmodule

// File: rtl/fifo_bist_reader.sv
// Read-side FIFO BIST consumer: pops NUM_WORDS words, checks them against the regenerated
// pattern and reports pass/fail, error count, first mismatch and stall timeout.
module fifo_bist_reader
  import fifo_bist_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_WORDS  = 16,
  parameter int SEED       = 1,
  parameter int TIMEOUT    = 64,
  localparam int IDX_W     = $clog2(NUM_WORDS + 1),
  localparam int TO_W      = $clog2(TIMEOUT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            pat_sel,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_en,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout_err,
  output logic [IDX_W-1:0]      err_cnt,
  output logic [IDX_W-1:0]      first_err_idx,
  output logic [DATA_WIDTH-1:0] first_err_data
);

  localparam logic [IDX_W-1:0] NUM_V   = IDX_W'(NUM_WORDS);
  localparam logic [IDX_W-1:0] LAST_V  = IDX_W'(NUM_WORDS - 1);
  localparam logic [IDX_W-1:0] ONE_IDX = IDX_W'(1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0]  ONE_TO  = TO_W'(1);

  bist_state_t           state_r;
  logic [IDX_W-1:0]      issued_r;
  logic [TO_W-1:0]       stall_r;
  logic                  cmp_vld_r;
  logic [IDX_W-1:0]      cmp_idx_r;
  logic [DATA_WIDTH-1:0] exp_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  pass_r;
  logic                  timeout_err_r;
  logic [IDX_W-1:0]      err_cnt_r;
  logic [IDX_W-1:0]      first_err_idx_r;
  logic [DATA_WIDTH-1:0] first_err_data_r;

  logic                  start_ok_s;
  logic                  r_en_s;
  logic                  mismatch_s;
  logic [IDX_W-1:0]      err_next_s;
  logic [DATA_WIDTH-1:0] pattern_s;

  bist_pattern_gen #(
    .DATA_WIDTH (DATA_WIDTH),
    .SEED       (SEED)
  ) u_pattern_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (start_ok_s),
    .adv     (r_en_s),
    .pat_sel (pat_sel),
    .pattern (pattern_s)
  );

  // Read issue, start acceptance and compare result for the word returned this cycle
  always_comb begin
    start_ok_s = start && ((state_r == IDLE) || (state_r == DONE));
    r_en_s     = (state_r == RUN) && !empty && (issued_r < NUM_V);
    mismatch_s = cmp_vld_r && (r_data != exp_r);
    err_next_s = mismatch_s ? (err_cnt_r + ONE_IDX) : err_cnt_r;
  end

  // Run control FSM with compare pipeline and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r          <= IDLE;
      issued_r         <= '0;
      stall_r          <= '0;
      cmp_vld_r        <= 1'b0;
      cmp_idx_r        <= '0;
      exp_r            <= '0;
      busy_r           <= 1'b0;
      done_r           <= 1'b0;
      pass_r           <= 1'b0;
      timeout_err_r    <= 1'b0;
      err_cnt_r        <= '0;
      first_err_idx_r  <= '0;
      first_err_data_r <= '0;
    end else begin
      cmp_vld_r <= r_en_s;
      if (r_en_s) begin
        exp_r     <= pattern_s;
        cmp_idx_r <= issued_r;
      end
      // The compare runs regardless of state so a compare pending at timeout still lands
      if (mismatch_s) begin
        err_cnt_r <= err_next_s;
        if (err_cnt_r == '0) begin
          first_err_idx_r  <= cmp_idx_r;
          first_err_data_r <= r_data;
        end
      end
      case (state_r)
        IDLE, DONE: begin
          if (start_ok_s) begin
            state_r          <= RUN;
            busy_r           <= 1'b1;
            done_r           <= 1'b0;
            pass_r           <= 1'b0;
            timeout_err_r    <= 1'b0;
            err_cnt_r        <= '0;
            first_err_idx_r  <= '0;
            first_err_data_r <= '0;
            issued_r         <= '0;
            stall_r          <= '0;
          end
        end
        RUN: begin
          if (r_en_s) begin
            issued_r <= issued_r + ONE_IDX;
            stall_r  <= '0;
            if (issued_r == LAST_V) begin
              state_r <= DRAIN;
            end
          end else if (empty) begin
            if (stall_r == TO_LAST) begin
              state_r       <= DONE;
              busy_r        <= 1'b0;
              done_r        <= 1'b1;
              pass_r        <= 1'b0;
              timeout_err_r <= 1'b1;
            end else begin
              stall_r <= stall_r + ONE_TO;
            end
          end
        end
        DRAIN: begin
          state_r <= DONE;
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
          pass_r  <= (err_next_s == '0);
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign r_en           = r_en_s;
  assign busy           = busy_r;
  assign done           = done_r;
  assign pass           = pass_r;
  assign timeout_err    = timeout_err_r;
  assign err_cnt        = err_cnt_r;
  assign first_err_idx  = first_err_idx_r;
  assign first_err_data = first_err_data_r;

endmodule

// File: tb/tb_fifo_bist_reader.sv
// Scoreboard bench for fifo_bist_reader: a queue-based FIFO model feeds the DUT, expected
// run results are queued at START and checked by a monitor when DONE rises.
module tb_fifo_bist_reader;

  localparam int DW = 8;
  localparam int NW = 16;
  localparam int TO = 64;
  localparam int IW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    pat_sel = 2'b00;
  logic          empty = 1'b1;
  logic [DW-1:0] r_data = 8'h00;
  logic          r_en, busy, done, pass, timeout_err;
  logic [IW-1:0] err_cnt, first_err_idx;
  logic [DW-1:0] first_err_data;

  typedef struct {
    int pass;
    int tmo;
    int err;
    int idx;
    int data;
    int reads;
    int gap;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  logic [DW-1:0] fifo_q[$];
  int            checks = 0;
  int            fails = 0;
  int            cyc = 0;
  int            rd_count = 0;
  int            rd_base = 0;
  int            last_rd = 0;
  int            bcnt = 0;
  bit            burst = 1'b0;
  bit            gate = 1'b0;
  logic          done_d = 1'b0;

  fifo_bist_reader #(
    .DATA_WIDTH (DW),
    .NUM_WORDS  (NW),
    .SEED       (1),
    .TIMEOUT    (TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .pat_sel        (pat_sel),
    .empty          (empty),
    .r_data         (r_data),
    .r_en           (r_en),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .timeout_err    (timeout_err),
    .err_cnt        (err_cnt),
    .first_err_idx  (first_err_idx),
    .first_err_data (first_err_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h) at cycle %0d", name, act, act, req, req, cyc);
    end
  endtask

  function automatic exp_t mk(input int p, input int t, input int e, input int i,
                              input int d, input int r, input int g);
    exp_t x;
    x.pass = p; x.tmo = t; x.err = e; x.idx = i; x.data = d; x.reads = r; x.gap = g;
    return x;
  endfunction

  function automatic logic [DW-1:0] model(input int sel, input int i);
    case (sel)
      0:       return 8'((1 + i) % 256);
      1:       return (i % 2 == 1) ? 8'hAA : 8'h55;
      2:       return 8'(1 << ((1 + i) % 8));
      default: return (i % 2 == 1) ? 8'hFF : 8'h00;
    endcase
  endfunction

  // FIFO read port: data appears the cycle after R_EN is sampled
  always @(posedge clk) begin
    cyc++;
    if (r_en) begin
      rd_count++;
      last_rd = cyc;
      if (fifo_q.size() > 0) r_data <= fifo_q.pop_front();
      else                   r_data <= 8'hEE;
    end
  end

  // Empty flag, optionally gated in 3-cycle bursts
  always @(negedge clk) begin
    if (burst) begin
      bcnt++;
      if (bcnt == 3) begin
        gate = !gate;
        bcnt = 0;
      end
    end else begin
      gate = 1'b0;
      bcnt = 0;
    end
    empty = gate || (fifo_q.size() == 0);
  end

  // Read-protocol monitor, mid low phase
  always @(negedge clk) begin
    #3;
    if (r_en) begin
      check("rd_while_empty", int'(empty), 0);
      check("rd_outside_busy", int'(busy), 1);
    end
  end

  // Result monitor: pop the expectation when DONE rises
  always @(negedge clk) begin
    if (done && !done_d) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", int'(done), 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("pass", int'(pass), mon_e.pass);
        check("timeout_err", int'(timeout_err), mon_e.tmo);
        check("err_cnt", int'(err_cnt), mon_e.err);
        check("first_err_idx", int'(first_err_idx), mon_e.idx);
        check("first_err_data", int'(first_err_data), mon_e.data);
        check("busy_at_done", int'(busy), 0);
        check("reads", rd_count - rd_base, mon_e.reads);
        check("done_gap", cyc - last_rd, mon_e.gap);
      end
    end
    done_d = done;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic preload(input int sel, input int n, input int bad1, input logic [DW-1:0] v1,
                         input int bad2, input logic [DW-1:0] v2);
    for (int i = 0; i < n; i++) begin
      if (i == bad1)      fifo_q.push_back(v1);
      else if (i == bad2) fifo_q.push_back(v2);
      else                fifo_q.push_back(model(sel, i));
    end
  endtask

  task automatic launch(input int sel, input bit scored, input exp_t e);
    @(negedge clk);
    if (scored) exp_q.push_back(e);
    pat_sel = 2'(sel);
    start   = 1'b1;
    rd_base = rd_count;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic wait_scored(input int bound);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("done_within_bound", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_r_en"}, int'(r_en), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_pass"}, int'(pass), 0);
    check({tag, "_timeout_err"}, int'(timeout_err), 0);
    check({tag, "_err_cnt"}, int'(err_cnt), 0);
    check({tag, "_first_err_idx"}, int'(first_err_idx), 0);
    check({tag, "_first_err_data"}, int'(first_err_data), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state
    rst = 1'b1;
    tick(3);
    check_all_zero("reset");
    rst = 1'b0;
    tick(2);

    // 1: clean incrementing run
    preload(0, 16, -1, 8'h00, -1, 8'h00);
    tick(1);
    launch(0, 1'b1, mk(1, 0, 0, 0, 0, 16, 1));
    wait_scored(400);
    tick(2);

    // 2: words 5 and 9 corrupted
    preload(0, 16, 5, 8'h46, 9, 8'h0B);
    tick(1);
    launch(0, 1'b1, mk(0, 0, 2, 5, 8'h46, 16, 1));
    wait_scored(400);
    tick(2);

    // 3: bursty writer, all four patterns
    for (int s = 0; s < 4; s++) begin
      burst = 1'b1;
      preload(s, 16, -1, 8'h00, -1, 8'h00);
      tick(1);
      launch(s, 1'b1, mk(1, 0, 0, 0, 0, 16, 1));
      wait_scored(400);
      burst = 1'b0;
      tick(2);
    end

    // 4: only 10 words -> stall timeout after 64 empty cycles
    preload(0, 10, -1, 8'h00, -1, 8'h00);
    tick(1);
    launch(0, 1'b1, mk(0, 1, 0, 0, 0, 10, 64));
    wait_scored(400);
    preload(0, 3, -1, 8'h00, -1, 8'h00);
    tick(6);
    check("no_read_after_timeout", rd_count - rd_base, 10);
    check("done_held", int'(done), 1);
    fifo_q.delete();
    tick(2);

    // 5: reset after 7 reads, then a clean rerun
    preload(0, 16, -1, 8'h00, -1, 8'h00);
    tick(1);
    launch(0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0));
    n = 0;
    while ((rd_count - rd_base) < 7 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reads_before_rst", rd_count - rd_base, 7);
    check("busy_before_rst", int'(busy), 1);
    #2 rst = 1'b1;
    #1 check_all_zero("mid_rst");
    @(negedge clk);
    fifo_q.delete();
    tick(2);
    rst = 1'b0;
    tick(2);
    preload(0, 16, -1, 8'h00, -1, 8'h00);
    tick(1);
    launch(0, 1'b1, mk(1, 0, 0, 0, 0, 16, 1));
    wait_scored(400);
    tick(2);

    // 6: START during RUN ignored, START in DONE clears and restarts
    burst = 1'b1;
    preload(0, 16, 2, 8'h33, -1, 8'h00);
    tick(1);
    launch(0, 1'b1, mk(0, 0, 1, 2, 8'h33, 16, 1));
    n = 0;
    while (err_cnt != 5'd1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("err_seen_mid_run", int'(err_cnt), 1);
    start   = 1'b1;
    pat_sel = 2'b11;
    @(negedge clk);
    start   = 1'b0;
    check("busy_after_ignored_start", int'(busy), 1);
    check("err_kept_after_ignored_start", int'(err_cnt), 1);
    wait_scored(400);
    burst = 1'b0;
    tick(2);
    preload(3, 16, -1, 8'h00, -1, 8'h00);
    tick(1);
    launch(3, 1'b1, mk(1, 0, 0, 0, 0, 16, 1));
    check("restart_done_clr", int'(done), 0);
    check("restart_busy", int'(busy), 1);
    check("restart_err_clr", int'(err_cnt), 0);
    check("restart_idx_clr", int'(first_err_idx), 0);
    check("restart_data_clr", int'(first_err_data), 0);
    wait_scored(400);
    tick(5);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
